ram_responder: RTL and testbench

Word-addressed, latency-configurable memory responder for the cpu_ram_if protocol. It is the target end of the interface, driven by a board wrapper or the CPU memory path.
- Accepts read and write requests.
- Reports progress on ramstate (FREE/BUSY/ACCESS/ERROR).
- Returns read data on ramload.
- Used in place of the vendor RAM for simulation and FPGA bring-up, with deterministic, parameterised wait states.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/ram_responder.sv | 106 ++++++++++
 tb/tb_ram_responder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-interface types: data word and the cpu_ram_if progress states.
package cpu_types_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned RAM_LAT_W = 4;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/ram_responder.sv
// Word-addressed cpu_ram_if target with a fixed, parameterised number of BUSY wait states.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LAT       = 2
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
);

    localparam int unsigned          DEPTH    = 2 ** ADDR_BITS;
    localparam logic [RAM_LAT_W-1:0] CNT_INIT = RAM_LAT_W'(LAT - 1);

    word_t                mem [DEPTH];
    logic [ADDR_BITS-1:0] cap_idx;
    logic                 cap_ren;
    logic                 cap_wen;
    logic [RAM_LAT_W-1:0] cnt;

    logic [ADDR_BITS-1:0] idx_c;
    logic                 any_req_c;
    logic                 addr_ok_c;
    logic                 valid_c;
    logic                 illegal_c;
    logic                 changed_c;
    logic                 commit_c;
    logic                 unused_lsb;

    // Request classification; out-of-range addresses are rejected, never truncated.
    assign idx_c      = ramaddr[ADDR_BITS+1:2];
    assign addr_ok_c  = (ramaddr[WORD_W-1:ADDR_BITS+2] == '0);
    assign any_req_c  = ramREN | ramWEN;
    assign valid_c    = (ramREN ^ ramWEN) & addr_ok_c;
    assign illegal_c  = any_req_c & ~valid_c;
    assign changed_c  = (ramREN != cap_ren) | (ramWEN != cap_wen) | (idx_c != cap_idx);
    assign commit_c   = !RST && (ramstate == BUSY) && valid_c && !changed_c && (cnt == '0);
    assign unused_lsb = ^ramaddr[1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            ramstate <= FREE;
            ramload  <= '0;
            cnt      <= '0;
            cap_ren  <= 1'b0;
            cap_wen  <= 1'b0;
            cap_idx  <= '0;
        end else begin
            case (ramstate)
                // ACCESS behaves like FREE: a still-asserted request starts a new transaction.
                FREE, ACCESS: begin
                    if (valid_c) begin
                        ramstate <= BUSY;
                        cap_ren  <= ramREN;
                        cap_wen  <= ramWEN;
                        cap_idx  <= idx_c;
                        cnt      <= CNT_INIT;
                    end else if (illegal_c) begin
                        ramstate <= ERROR;
                    end else begin
                        ramstate <= FREE;
                    end
                end
                BUSY: begin
                    if (!any_req_c) begin
                        ramstate <= FREE;
                    end else if (illegal_c) begin
                        ramstate <= ERROR;
                    end else if (changed_c) begin
                        cap_ren <= ramREN;
                        cap_wen <= ramWEN;
                        cap_idx <= idx_c;
                        cnt     <= CNT_INIT;
                    end else if (cnt != '0) begin
                        cnt <= cnt - RAM_LAT_W'(1);
                    end else begin
                        ramstate <= ACCESS;
                        if (cap_ren) begin
                            ramload <= mem[cap_idx];
                        end
                    end
                end
                ERROR: begin
                    if (!any_req_c) begin
                        ramstate <= FREE;
                    end
                end
                default: ramstate <= FREE;
            endcase
        end
    end

    // Array is left out of reset so it maps onto a plain synchronous-write memory.
    always_ff @(posedge CLK) begin
        if (commit_c && cap_wen) begin
            mem[cap_idx] <= ramstore;
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: transaction-level model feeding a per-cycle expectation queue.
module tb_ram_responder;
    import cpu_types_pkg::*;

    localparam int unsigned ADDR_BITS = 8;
    localparam int unsigned LAT       = 2;

    logic      CLK = 1'b0;
    logic      RST;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    ram_responder #(.ADDR_BITS(ADDR_BITS), .LAT(LAT)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        ramstate_t st;
        word_t     ld;
    } exp_t;

    exp_t  exp_q[$];
    word_t mdl_mem [256];
    word_t mdl_load;
    int    checks   = 0;
    int    errors   = 0;
    int    cyc_n    = 0;
    int    req_cyc  = 0;
    int    last_lat = -1;

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // One clock: record what the outputs must be after this edge.
    task automatic cyc(input ramstate_t st);
        exp_t e;
        @(posedge CLK);
        e.st = st;
        e.ld = mdl_load;
        exp_q.push_back(e);
        #1;
    endtask

    // Clean transaction: LAT BUSY cycles, one ACCESS, initiator drops in ACCESS.
    task automatic xact(input logic ren, input logic wen, input word_t addr, input word_t data);
        int unsigned w;
        w        = int'(addr[ADDR_BITS+1:2]);
        ramREN   = ren;
        ramWEN   = wen;
        ramaddr  = addr;
        ramstore = ~data;
        for (int i = 0; i < int'(LAT); i++) begin
            cyc(BUSY);
            ramstore = data;
        end
        if (ren) mdl_load = mdl_mem[w];
        else     mdl_mem[w] = data;
        cyc(ACCESS);
        ramREN = 1'b0;
        ramWEN = 1'b0;
        cyc(FREE);
    endtask

    // Compare process plus a latency monitor measured from the request edge.
    always @(negedge CLK) begin
        exp_t e;
        cyc_n++;
        if (!RST && ramstate == FREE && (ramREN || ramWEN)) req_cyc = cyc_n;
        if (ramstate == ACCESS) last_lat = cyc_n - req_cyc;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ramstate", 32'(ramstate), 32'(e.st));
            chk("ramload", ramload, e.ld);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST      = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        mdl_load = '0;
        cyc(FREE);
        cyc(FREE);
        RST = 1'b0;
        repeat (5) cyc(FREE);

        // Known contents for every word read later
        xact(1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D);
        xact(1'b0, 1'b1, 32'h0000_0008, 32'hA5A5_0002);
        xact(1'b0, 1'b1, 32'h0000_0014, 32'h5555_0005);
        xact(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_0020);

        // Write then read 0x10
        xact(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        chk("lat_wr", 32'(last_lat), 32'd3);
        xact(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        chk("lat_rd", 32'(last_lat), 32'd3);
        chk("rd_0x10", ramload, 32'hDEAD_BEEF);

        // Address change in first BUSY cycle restarts the wait
        ramREN  = 1'b1;
        ramWEN  = 1'b0;
        ramaddr = 32'h0000_0010;
        cyc(BUSY);
        ramaddr = 32'h0000_0014;
        repeat (LAT) cyc(BUSY);
        mdl_load = mdl_mem[5];
        cyc(ACCESS);
        ramREN = 1'b0;
        cyc(FREE);
        chk("lat_restart", 32'(last_lat), 32'd4);
        chk("rd_0x14", ramload, 32'h5555_0005);

        // Both enables high
        ramREN   = 1'b1;
        ramWEN   = 1'b1;
        ramaddr  = 32'h0000_0010;
        ramstore = 32'h1111_1111;
        repeat (3) cyc(ERROR);
        ramREN = 1'b0;
        ramWEN = 1'b0;
        cyc(FREE);
        // Out-of-range address, request type switched while in ERROR
        ramREN   = 1'b1;
        ramaddr  = 32'h0000_0400;
        repeat (2) cyc(ERROR);
        ramREN = 1'b0;
        ramWEN = 1'b1;
        cyc(ERROR);
        ramWEN = 1'b0;
        cyc(FREE);
        // Request turns illegal mid-BUSY
        ramREN  = 1'b1;
        ramaddr = 32'h0000_0008;
        cyc(BUSY);
        ramaddr = 32'h0000_0404;
        repeat (2) cyc(ERROR);
        ramREN = 1'b0;
        cyc(FREE);
        xact(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        chk("err_keep_0x10", ramload, 32'hDEAD_BEEF);
        xact(1'b1, 1'b0, 32'h0000_0000, 32'h0);
        chk("no_wrap_0x0", ramload, 32'h0BAD_F00D);

        // Reset in the second BUSY cycle aborts the write
        ramWEN   = 1'b1;
        ramaddr  = 32'h0000_0020;
        ramstore = 32'h1234_5678;
        cyc(BUSY);
        cyc(BUSY);
        RST      = 1'b1;
        mdl_load = '0;
        cyc(FREE);
        RST    = 1'b0;
        ramWEN = 1'b0;
        cyc(FREE);
        xact(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        chk("rst_abort_0x20", ramload, 32'hCAFE_0020);

        // Read held through ACCESS: back-to-back transactions
        ramREN  = 1'b1;
        ramaddr = 32'h0000_0008;
        for (int k = 0; k < 3; k++) begin
            repeat (LAT) cyc(BUSY);
            mdl_load = mdl_mem[2];
            cyc(ACCESS);
        end
        ramREN = 1'b0;
        cyc(FREE);
        chk("b2b_0x8", ramload, 32'hA5A5_0002);

        cyc(FREE);
        @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
